pipe_chain: RTL and testbench

//   Parametrised elastic register chain: WIDTH-bit words pass through DEPTH registered stages.

---
 rtl/pipe_chain_pkg.sv | 19 +
 rtl/pipe_stage.sv | 55 +++++
 rtl/pipe_chain.sv | 91 +++++++++
 tb/tb_pipe_chain.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_chain_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_chain_pkg
// Description : Shared helpers for the elastic register chain.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_chain_pkg;

    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Applied per bit so the helper serves any word width.
    function automatic logic xform(input logic d, input logic inv);
        return inv ? ~d : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage
// Description : One valid/data register pair of the elastic chain.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage
    import pipe_chain_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int INVERT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             load,
    input  logic             v_up,
    input  logic [WIDTH-1:0] d_up,
    output logic             v,
    output logic [WIDTH-1:0] d
);

    localparam logic c_inv = (INVERT != 0);

    logic             r_v;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] w_xf;

    always_comb begin
        w_xf = '0;
        for (int b = 0; b < WIDTH; b++) begin
            w_xf[b] = xform(d_up[b], c_inv);
        end
    end

    // Flush drops validity only; data is held so no extra write occurs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= 1'b0;
            r_d <= '0;
        end else if (flush) begin
            r_v <= 1'b0;
        end else if (load) begin
            r_v <= v_up;
            if (v_up) begin
                r_d <= w_xf;
            end
        end
    end

    assign v = r_v;
    assign d = r_d;

endmodule
`default_nettype wire

// File: rtl/pipe_chain.sv
`default_nettype none
// ============================================================================
// Module      : pipe_chain
// Description : DEPTH-stage elastic register chain with optional per-stage
//               inversion, valid/ready on both ends, flush and occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_chain
    import pipe_chain_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int INVERT = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [occ_w(DEPTH)-1:0]   occupancy
);

    localparam int OCC_W = occ_w(DEPTH);

    logic [DEPTH:0]   w_rdy;
    logic [DEPTH-1:0] w_v;
    logic [DEPTH-1:0] w_vup;
    logic [WIDTH-1:0] w_d   [DEPTH];
    logic [WIDTH-1:0] w_dup [DEPTH];
    logic             w_push;
    logic             w_pop;
    logic [OCC_W-1:0] r_occ;

    // Ready ripples back combinationally so a full chain still moves every cycle.
    assign w_rdy[DEPTH] = out_ready & ~flush;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            if (i == 0) begin : g_head
                assign w_vup[i] = in_valid;
                assign w_dup[i] = in_data;
            end else begin : g_body
                assign w_vup[i] = w_v[i-1];
                assign w_dup[i] = w_d[i-1];
            end

            assign w_rdy[i] = ~w_v[i] | w_rdy[i+1];

            pipe_stage #(
                .WIDTH  (WIDTH),
                .INVERT (INVERT)
            ) u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .flush (flush),
                .load  (w_rdy[i]),
                .v_up  (w_vup[i]),
                .d_up  (w_dup[i]),
                .v     (w_v[i]),
                .d     (w_d[i])
            );
        end
    endgenerate

    assign in_ready  = w_rdy[0] & ~flush;
    assign out_valid = w_v[DEPTH-1] & ~flush;
    assign out_data  = w_d[DEPTH-1];

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else if (w_push && !w_pop) begin
            r_occ <= r_occ + OCC_W'(1);
        end else if (w_pop && !w_push) begin
            r_occ <= r_occ - OCC_W'(1);
        end
    end

    assign occupancy = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_pipe_chain.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_chain
// Description : Self-checking bench for pipe_chain against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_chain;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 4;
    localparam int INVERT = 0;

    typedef struct {
        logic [WIDTH-1:0] d;
        int               t;
    } item_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       occupancy;

    // Inversion-check instances
    logic             iv_valid = 1'b0;
    logic [WIDTH-1:0] iv_data = 8'hA5;
    logic             i3_in_ready, i3_out_valid, i2_in_ready, i2_out_valid;
    logic [WIDTH-1:0] i3_out_data, i2_out_data;
    logic [1:0]       i3_occ, i2_occ;

    int    checks   = 0;
    int    failures = 0;
    int    e        = 0;
    item_t q[$];
    logic [WIDTH-1:0] got[$];

    always #5 clk = ~clk;

    pipe_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INVERT(INVERT)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    pipe_chain #(.WIDTH(WIDTH), .DEPTH(3), .INVERT(1)) u_inv3 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(iv_valid), .in_ready(i3_in_ready), .in_data(iv_data),
        .out_valid(i3_out_valid), .out_ready(1'b0), .out_data(i3_out_data),
        .occupancy(i3_occ)
    );

    pipe_chain #(.WIDTH(WIDTH), .DEPTH(2), .INVERT(1)) u_inv2 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(iv_valid), .in_ready(i2_in_ready), .in_data(iv_data),
        .out_valid(i2_out_valid), .out_ready(1'b0), .out_data(i2_out_data),
        .occupancy(i2_occ)
    );

    function automatic logic [WIDTH-1:0] net(input logic [WIDTH-1:0] w);
        return ((INVERT != 0) && (DEPTH % 2 == 1)) ? ~w : w;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: the chain is a DEPTH-entry FIFO whose head becomes visible
    // DEPTH-1 edges after it was accepted; input is ready if space exists
    // or the output is draining this cycle.
    task automatic cycle();
        logic er, ev, push, pop;
        @(negedge clk);
        er = !flush && ((q.size() < DEPTH) || out_ready);
        ev = !flush && (q.size() > 0) && ((e - q[0].t) >= DEPTH - 1);
        check("in_ready", 32'(in_ready), 32'(er));
        check("out_valid", 32'(out_valid), 32'(ev));
        check("occupancy", 32'(occupancy), 32'(q.size()));
        if (ev) check("out_data", 32'(out_data), 32'(net(q[0].d)));
        if (out_valid && out_ready) got.push_back(out_data);
        pop  = ev && out_ready;
        push = in_valid && er;
        @(posedge clk);
        e++;
        if (flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back('{in_data, e});
        end
        #1;
    endtask

    task automatic check_got(input string tag, input int n, input int first);
        check({tag, "_count"}, 32'(got.size()), 32'(n));
        for (int k = 0; k < n && k < got.size(); k++) begin
            check({tag, "_word"}, 32'(got[k]), 32'(net(WIDTH'(first + k))));
        end
        got.delete();
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle();

        // Streaming 0x01..0x10
        out_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(k);
            cycle();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 6; k++) cycle();
        check_got("stream", 16, 1);

        // Inversion: DEPTH=3 inverts, DEPTH=2 passes through
        iv_valid = 1'b1;
        cycle();
        iv_valid = 1'b0;
        cycle();
        check("inv3_early_valid", 32'(i3_out_valid), 32'd0);
        check("inv2_valid", 32'(i2_out_valid), 32'd1);
        check("inv2_data", 32'(i2_out_data), 32'hA5);
        cycle();
        check("inv3_valid", 32'(i3_out_valid), 32'd1);
        check("inv3_data", 32'(i3_out_data), 32'h5A);

        // Backpressure: push 6 with output stalled
        out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(k);
            while (!in_ready && k > 4 && q.size() == DEPTH) begin
                cycle();
                if (e > 100000) break;
                if (k > 4) break;
            end
            cycle();
        end
        check("bp_occupancy", 32'(occupancy), 32'(DEPTH));
        check("bp_in_ready", 32'(in_ready), 32'd0);
        // Words 5 and 6 were offered while full and never accepted; resend.
        out_ready = 1'b1;
        for (int k = 5; k <= 6; k++) begin
            in_data = WIDTH'(k);
            cycle();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        cycle();
        check("bp_refill_occ", 32'(occupancy), 32'(DEPTH));
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) cycle();
        check_got("bp", 6, 1);

        // Full pop+push: fill to DEPTH, then 10 simultaneous pop/push cycles
        out_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(8'h40 + k);
            cycle();
        end
        check("full_occ", 32'(occupancy), 32'(DEPTH));
        out_ready = 1'b1;
        for (int k = DEPTH; k < DEPTH + 10; k++) begin
            in_data = WIDTH'(8'h40 + k);
            cycle();
            check("full_steady_occ", 32'(occupancy), 32'(DEPTH));
        end
        check_got("full", 10, 8'h40);
        in_valid = 1'b0;
        for (int k = 0; k < 6; k++) cycle();
        got.delete();

        // Flush with occupancy 3 and both handshakes offered
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(8'h70 + k);
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        check("pre_flush_occ", 32'(occupancy), 32'd3);
        flush = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        cycle();
        check("flush_occ", 32'(occupancy), 32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_no_pop", 32'(got.size()), 32'd0);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            in_data   = WIDTH'($urandom);
            cycle();
        end
        got.delete();

        // Asynchronous reset mid-traffic
        in_valid  = 1'b1;
        out_ready = 1'b0;
        flush     = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_data = WIDTH'($urandom);
            cycle();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_occupancy", 32'(occupancy), 32'd0);
        check("async_out_data", 32'(out_data), 32'd0);
        q.delete();
        got.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) cycle();
        check("post_reset_no_out", 32'(got.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
